// File: rtl/reg_file_sp_pkg.sv
// Shared constants and types for the reg_file_sp register file and its read ports.
package reg_file_sp_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;
  localparam int ADDR_W   = 2;

  localparam logic [ADDR_W-1:0] REG_SP   = 2'd3;
  localparam logic [DATA_W-1:0] SP_RESET = 8'hFF;

  // Bit positions inside the write-back enable bus
  localparam int WEN_DATA = 0;
  localparam int WEN_SP   = 1;

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

  function automatic reg_array_t reset_regs();
    reg_array_t r;
    r         = '0;
    r[REG_SP] = SP_RESET;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_sp_read_port.sv
// One decode read port: address decode into the register view and the ID/EX output
// register with flush-over-stall priority.
module reg_read_port
  import reg_file_sp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  input  reg_array_t        regs,
  input  logic              id_stall,
  input  logic              id_flush,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = regs[rd_addr];
    if (id_flush) begin
      rd_data_d = '0;
    end else if (id_stall) begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/reg_file_sp.sv
// 4x8 register file with R3 as stack pointer, dedicated SP update port and two
// registered read ports. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module reg_file_sp
  import reg_file_sp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        reg_file_wenWB,
  input  logic              sp_mux_sWB_out,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] WB_data,
  input  logic [DATA_W-1:0] sp_next,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              id_stall,
  input  logic              id_flush,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_conflict
);

  reg_array_t regs_q;
  reg_array_t regs_d;
  reg_array_t rd_src;
  logic       data_we;
  logic       sp_we;
  logic       sp_conflict_q;
  logic       sp_conflict_d;

  // Data write is applied last so it overrides the SP port on a collision at R3
  always_comb begin
    data_we = reg_file_wenWB[WEN_DATA];
    sp_we   = reg_file_wenWB[WEN_SP] && sp_mux_sWB_out;
    regs_d  = regs_q;
    if (sp_we) begin
      regs_d[REG_SP] = sp_next;
    end
    if (data_we) begin
      regs_d[wb_addr] = WB_data;
    end
    sp_conflict_d = data_we && sp_we && (wb_addr == REG_SP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q        <= reset_regs();
      sp_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      sp_conflict_q <= sp_conflict_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Post-write view already carries the collision resolution, so reads agree with the array
  assign rd_src = regs_d;
`else
  assign rd_src = regs_q;
`endif

  reg_read_port u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (ra_addr),
    .regs    (rd_src),
    .id_stall(id_stall),
    .id_flush(id_flush),
    .rd_data (ra_data)
  );

  reg_read_port u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rb_addr),
    .regs    (rd_src),
    .id_stall(id_stall),
    .id_flush(id_flush),
    .rd_data (rb_data)
  );

  assign sp_out      = regs_q[REG_SP];
  assign sp_conflict = sp_conflict_q;

endmodule

// File: tb/tb_reg_file_sp.sv
// Self-checking bench for reg_file_sp: directed scenarios plus a randomized run
// against a behavioural register-file model.
module tb_reg_file_sp;

  logic       clk;
  logic       rst_n;
  logic [1:0] wen;
  logic       sp_mux;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic [7:0] sp_next;
  logic [1:0] ra_addr;
  logic [1:0] rb_addr;
  logic       id_stall;
  logic       id_flush;
  logic [7:0] ra_data;
  logic [7:0] rb_data;
  logic [7:0] sp_out;
  logic       sp_conflict;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks;
  int failures;

  // Behavioural model state
  logic [7:0] mem [4];
  logic [7:0] exp_ra;
  logic [7:0] exp_rb;
  logic       exp_conf;

  reg_file_sp dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_file_wenWB(wen),
    .sp_mux_sWB_out(sp_mux),
    .wb_addr       (wb_addr),
    .WB_data       (wb_data),
    .sp_next       (sp_next),
    .ra_addr       (ra_addr),
    .rb_addr       (rb_addr),
    .id_stall      (id_stall),
    .id_flush      (id_flush),
    .ra_data       (ra_data),
    .rb_data       (rb_data),
    .sp_out        (sp_out),
    .sp_conflict   (sp_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wen      = 2'b00;
    sp_mux   = 1'b0;
    id_stall = 1'b0;
    id_flush = 1'b0;
  endtask

  // Predict the effect of the upcoming edge from current inputs, then advance one clock.
  task automatic step();
    logic [7:0] nxt [4];
    logic [7:0] src [4];
    bit         dw;
    bit         sw;
    dw = wen[0];
    sw = wen[1] && sp_mux;
    nxt = mem;
    if (sw) nxt[3] = sp_next;
    if (dw) nxt[wb_addr] = wb_data;
    src = BYPASS ? nxt : mem;
    if (!rst_n) begin
      exp_ra   = 8'h00;
      exp_rb   = 8'h00;
      exp_conf = 1'b0;
      mem      = '{8'h00, 8'h00, 8'h00, 8'hFF};
    end else begin
      if (id_flush) begin
        exp_ra = 8'h00;
        exp_rb = 8'h00;
      end else if (!id_stall) begin
        exp_ra = src[ra_addr];
        exp_rb = src[rb_addr];
      end
      exp_conf = dw && sw && (wb_addr == 2'd3);
      mem      = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    wen = 2'b01; wb_addr = 2'd0; wb_data = 8'h77;
    ra_addr = 2'd0; rb_addr = 2'd3; sp_next = 8'h00;
    step();
    idle();
    step();
    checks++; if (ra_data !== 8'h00) begin failures++; $display("FAIL reset_ra got=%h exp=00", ra_data); end
    checks++; if (rb_data !== 8'h00) begin failures++; $display("FAIL reset_rb got=%h exp=00", rb_data); end
    checks++; if (sp_out !== 8'hFF) begin failures++; $display("FAIL reset_sp got=%h exp=ff", sp_out); end
    checks++; if (sp_conflict !== 1'b0) begin failures++; $display("FAIL reset_conf got=%b exp=0", sp_conflict); end
    rst_n = 1'b1;
    ra_addr = 2'd3; rb_addr = 2'd0;
    step();
    checks++; if (ra_data !== 8'hFF) begin failures++; $display("FAIL reset_read_r3 got=%h exp=ff", ra_data); end
    checks++; if (rb_data !== 8'h00) begin failures++; $display("FAIL reset_write_discarded got=%h exp=00", rb_data); end
    $display("test_reset done");
  endtask

  task automatic test_data_write();
    wen = 2'b01; wb_addr = 2'd1; wb_data = 8'hA5;
    ra_addr = 2'd0; rb_addr = 2'd0;
    step();
    idle();
    ra_addr = 2'd1; rb_addr = 2'd0;
    step();
    checks++; if (ra_data !== 8'hA5) begin failures++; $display("FAIL data_read_r1 got=%h exp=a5", ra_data); end
    checks++; if (rb_data !== 8'h00) begin failures++; $display("FAIL data_r0_untouched got=%h exp=00", rb_data); end
    ra_addr = 2'd2; rb_addr = 2'd1;
    step();
    checks++; if (ra_data !== 8'h00) begin failures++; $display("FAIL data_r2_untouched got=%h exp=00", ra_data); end
    checks++; if (rb_data !== 8'hA5) begin failures++; $display("FAIL data_read_r1_b got=%h exp=a5", rb_data); end
    $display("test_data_write done");
  endtask

  task automatic test_sp_update();
    wen = 2'b10; sp_mux = 1'b1; sp_next = 8'hFE;
    step();
    checks++; if (sp_out !== 8'hFE) begin failures++; $display("FAIL sp_update got=%h exp=fe", sp_out); end
    wen = 2'b10; sp_mux = 1'b0; sp_next = 8'h10;
    step();
    checks++; if (sp_out !== 8'hFE) begin failures++; $display("FAIL sp_unqualified got=%h exp=fe", sp_out); end
    idle();
    $display("test_sp_update done");
  endtask

  task automatic test_collision();
    wen = 2'b11; sp_mux = 1'b1; wb_addr = 2'd3; wb_data = 8'h40; sp_next = 8'hFD;
    step();
    idle();
    checks++; if (sp_out !== 8'h40) begin failures++; $display("FAIL collision_sp got=%h exp=40", sp_out); end
    checks++; if (sp_conflict !== 1'b1) begin failures++; $display("FAIL collision_pulse got=%b exp=1", sp_conflict); end
    step();
    checks++; if (sp_conflict !== 1'b0) begin failures++; $display("FAIL collision_pulse_end got=%b exp=0", sp_conflict); end
    checks++; if (sp_out !== 8'h40) begin failures++; $display("FAIL collision_sp_hold got=%h exp=40", sp_out); end
    // SP write to R3 with the data port aimed elsewhere is not a collision
    wen = 2'b11; sp_mux = 1'b1; wb_addr = 2'd0; wb_data = 8'h09; sp_next = 8'h3F;
    step();
    idle();
    checks++; if (sp_conflict !== 1'b0) begin failures++; $display("FAIL no_collision_pulse got=%b exp=0", sp_conflict); end
    checks++; if (sp_out !== 8'h3F) begin failures++; $display("FAIL no_collision_sp got=%h exp=3f", sp_out); end
    $display("test_collision done");
  endtask

  task automatic test_bypass();
    logic [7:0] want;
    wen = 2'b01; wb_addr = 2'd2; wb_data = 8'h3C; ra_addr = 2'd2;
    step();
    idle();
    want = BYPASS ? 8'h3C : 8'h00;
    checks++; if (ra_data !== want) begin failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", ra_data, want); end
    step();
    checks++; if (ra_data !== 8'h3C) begin failures++; $display("FAIL bypass_following got=%h exp=3c", ra_data); end
    $display("test_bypass done");
  endtask

  task automatic test_stall_flush();
    ra_addr = 2'd1;
    step();
    checks++; if (ra_data !== 8'hA5) begin failures++; $display("FAIL stall_pre got=%h exp=a5", ra_data); end
    id_stall = 1'b1; wen = 2'b01; wb_addr = 2'd1; wb_data = 8'h11;
    step();
    wen = 2'b00;
    checks++; if (ra_data !== 8'hA5) begin failures++; $display("FAIL stall_hold got=%h exp=a5", ra_data); end
    step();
    checks++; if (ra_data !== 8'hA5) begin failures++; $display("FAIL stall_hold2 got=%h exp=a5", ra_data); end
    id_flush = 1'b1;
    step();
    checks++; if (ra_data !== 8'h00) begin failures++; $display("FAIL flush_over_stall got=%h exp=00", ra_data); end
    idle();
    step();
    checks++; if (ra_data !== 8'h11) begin failures++; $display("FAIL stall_release got=%h exp=11", ra_data); end
    $display("test_stall_flush done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst_n    = ($urandom_range(0, 29) != 0);
      wen      = 2'($urandom_range(0, 3));
      sp_mux   = 1'($urandom_range(0, 1));
      wb_addr  = 2'($urandom_range(0, 3));
      wb_data  = 8'($urandom);
      sp_next  = 8'($urandom);
      ra_addr  = 2'($urandom_range(0, 3));
      rb_addr  = 2'($urandom_range(0, 3));
      id_stall = ($urandom_range(0, 5) == 0);
      id_flush = ($urandom_range(0, 9) == 0);
      step();
      $display("txn %0d rst_n=%b wen=%b spm=%b wa=%0d wd=%h sp=%h ra=%0d rb=%0d st=%b fl=%b -> ra=%h rb=%h sp=%h cf=%b",
               n, rst_n, wen, sp_mux, wb_addr, wb_data, sp_next, ra_addr, rb_addr,
               id_stall, id_flush, ra_data, rb_data, sp_out, sp_conflict);
      checks++; if (ra_data !== exp_ra) begin failures++; $display("FAIL rand_ra n=%0d got=%h exp=%h", n, ra_data, exp_ra); end
      checks++; if (rb_data !== exp_rb) begin failures++; $display("FAIL rand_rb n=%0d got=%h exp=%h", n, rb_data, exp_rb); end
      checks++; if (sp_out !== mem[3]) begin failures++; $display("FAIL rand_sp n=%0d got=%h exp=%h", n, sp_out, mem[3]); end
      checks++; if (sp_conflict !== exp_conf) begin failures++; $display("FAIL rand_conf n=%0d got=%b exp=%b", n, sp_conflict, exp_conf); end
    end
    rst_n = 1'b1;
    idle();
    $display("test_random done");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mem      = '{8'h00, 8'h00, 8'h00, 8'hFF};
    exp_ra   = 8'h00;
    exp_rb   = 8'h00;
    exp_conf = 1'b0;
    @(negedge clk);
    test_reset();
    test_data_write();
    test_sp_update();
    test_collision();
    test_bypass();
    test_stall_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sp.md
Name: reg_file_sp

Overview:
- 4 x 8-bit register file (R0..R3) that consumes the write-back stage outputs: write data, write enables, SP-select.
- R3 is the stack pointer.
- Two read ports feed the decode stage. Read data is registered into the ID/EX boundary with stall/flush control.
- A dedicated SP update port handles PUSH/POP/CALL/RET post-decrement and post-increment results arriving alongside a data write.

Parameters:
- DATA_W, 8, register width.
- SP_RESET, 8'hFF, reset value of R3 (SP).
- SP_IDX, 3, index of the SP register.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- reg_file_wenWB  in  2  bit0 = data write enable, bit1 = SP write enable.
- sp_mux_sWB_out  in  1  1 = SP port carries an SP update (qualifies bit1).
- wb_addr  in  2  destination register of WB_data.
- WB_data  in  8  write-back data.
- sp_next  in  8  new SP value from the SP adder/subtractor.
- ra_addr  in  2  read port A address (decode).
- rb_addr  in  2  read port B address (decode).
- id_stall  in  1  hold read outputs.
- id_flush  in  1  zero read outputs.
- ra_data  out  8  registered read A.
- rb_data  out  8  registered read B.
- sp_out  out  8  current SP, combinational from R3.
- sp_conflict  out  1  registered pulse: both ports targeted R3 in one cycle.

Behaviour:
- Reset (rst_n=0 at posedge): R0..R2=0, R3=SP_RESET, ra_data=rb_data=0, sp_conflict=0.
  - Reset mid-operation discards any same-cycle write.
- Data write: at posedge, if wen[0], regs[wb_addr] <= WB_data.
- SP write: at posedge, if wen[1] && sp_mux_sWB_out, R3 <= sp_next.
  - wen[1] without sp_mux_sWB_out is ignored.
- Collision: both writes active and wb_addr==SP_IDX.
  - Data write wins (R3 <= WB_data).
  - sp_conflict=1 for exactly the next cycle.
  - Otherwise sp_conflict=0.
- Read latency: 1 cycle. At posedge ra_data <= rd(ra_addr), rb_data <= rd(rb_addr).
  - rd() is the current array value, with bypass when the feature is enabled.
- Priority: rst_n low > id_flush (outputs <= 0) > id_stall (outputs hold) > normal capture.
  - Writes to the array proceed regardless of stall/flush.
- No wrap logic inside the block. sp_next arithmetic (FF->00 on increment, 00->FF on decrement) is the supplier's responsibility and is stored as given.
- sp_out always reflects R3 as stored (no bypass).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: read port whose address matches a same-cycle active write captures the write value instead of the stale array value.
  - Data-port match uses WB_data.
  - SP-port match on address 3 uses sp_next.
  - On collision, WB_data is used, consistent with the array.
- Undefined: read captures the array value only. A same-cycle write is visible one cycle later, and the hazard unit must stall one extra cycle.

Decomposition:
- Shared package holds:
  - DATA_W.
  - REG_SP index constant (2'd3).
  - SP_RESET.
  - wen bit positions WEN_DATA=0 and WEN_SP=1.
- One natural sub-module, reg_read_port: address decode plus optional bypass mux plus stall/flush output register. Instantiated twice (A and B).

Test Plan:
- Reset: drive rst_n=0 for 2 cycles -> ra_data=rb_data=0, sp_out=8'hFF, sp_conflict=0. Read R3 next cycle -> ra_data=8'hFF.
- Data write/read: wen=01, wb_addr=1, WB_data=8'hA5; next cycle ra_addr=1 -> ra_data=8'hA5 one cycle later. R0/R2 unchanged at 0.
- SP update: wen=10, sp_mux_sWB_out=1, sp_next=8'hFE -> sp_out=8'hFE after the edge. Repeat with sp_mux_sWB_out=0, sp_next=8'h10 -> sp_out stays 8'hFE.
- Collision: wen=11, sp_mux_sWB_out=1, wb_addr=3, WB_data=8'h40, sp_next=8'hFD -> R3=8'h40, sp_conflict=1 for one cycle then 0.
- Bypass: same-cycle wen=01, wb_addr=2, WB_data=8'h3C, ra_addr=2.
  - With REGFILE_BYPASS_EN -> ra_data=8'h3C next cycle.
  - Without -> ra_data=old R2 (8'h00), and 8'h3C on the following capture.
- Stall/flush: ra_data=8'hA5, assert id_stall while R1 is changed to 8'h11 -> ra_data holds 8'hA5. Assert id_flush with id_stall -> ra_data=8'h00. Deassert both -> ra_data=8'h11.
